// File: rtl/stream_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_link_pkg
// Brief    : Shared widths, header field position and page FSM states.
// Revision : 1.0
// ============================================================================
package stream_link_pkg;

    localparam int DAT_W      = 54;
    localparam int BX_W       = 3;
    localparam int CNT_W      = 6;
    localparam int MAX_ITEMS  = 63;
    // Header words carry their BX in the low bits, as the readout side emits them.
    localparam int HDR_BX_LSB = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } page_state_e;

endpackage
`default_nettype wire

// File: rtl/page_item_counter.sv
`default_nettype none
// ============================================================================
// Module   : page_item_counter
// Brief    : Per-page item index with clear, increment and full detection.
// Revision : 1.0
// ============================================================================
module page_item_counter #(
    parameter int CNT_W     = 6,
    parameter int MAX_ITEMS = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc && !full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign full = (r_cnt == CNT_W'(MAX_ITEMS));

endmodule
`default_nettype wire

// File: rtl/stream_page_writer.sv
`default_nettype none
// ============================================================================
// Module   : stream_page_writer
// Brief    : Writes a merged header/data stream into BX-paged memory.
// Revision : 1.0
// ============================================================================
module stream_page_writer #(
    parameter int DAT_W     = stream_link_pkg::DAT_W,
    parameter int BX_W      = stream_link_pkg::BX_W,
    parameter int CNT_W     = stream_link_pkg::CNT_W,
    parameter int MAX_ITEMS = stream_link_pkg::MAX_ITEMS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DAT_W-1:0]      mem_dat_stream,
    input  logic                  valid,
    input  logic                  send_BX,
    input  logic                  flush,
    output logic                  wr_en,
    output logic [BX_W+CNT_W-1:0] wr_addr,
    output logic [DAT_W-1:0]      wr_dat,
    output logic [CNT_W-1:0]      number_out,
    output logic [BX_W-1:0]       number_BX,
    output logic                  number_valid,
    output logic                  overflow,
    output logic [7:0]            dropped
);

    import stream_link_pkg::*;

    page_state_e      r_state;
    page_state_e      w_state_nxt;
    logic [BX_W-1:0]  r_cur_bx;
    logic [CNT_W-1:0] w_cnt;
    logic             w_full;
    logic             w_data;
    logic             w_flush;
    logic             w_write;
    logic             w_close;
    logic             w_drop;
    logic             w_lost;
    logic             w_clr;
    logic [CNT_W-1:0] w_pub_cnt;

    // Header beats both data and flush on the same cycle.
    assign w_data  = valid && !send_BX;
    assign w_flush = flush && !send_BX;

    page_item_counter #(
        .CNT_W     (CNT_W),
        .MAX_ITEMS (MAX_ITEMS)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_write),
        .cnt   (w_cnt),
        .full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (send_BX) begin
            w_state_nxt = FILL;
        end else if (r_state == FILL && w_flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_write = (r_state == FILL) && w_data && !w_full;
        w_close = (r_state == FILL) && (send_BX || w_flush);
        w_drop  = w_data && ((r_state == IDLE) || w_full);
        w_lost  = w_data && (r_state == FILL) && w_full;
        w_clr   = send_BX || w_close;
    end

    // A word written alongside a flush still belongs to the closing page.
    assign w_pub_cnt = w_cnt + CNT_W'(w_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_bx     <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_dat       <= '0;
            number_out   <= '0;
            number_BX    <= '0;
            number_valid <= 1'b0;
            overflow     <= 1'b0;
            dropped      <= '0;
        end else begin
            wr_en        <= w_write;
            number_valid <= w_close;
            if (send_BX) begin
                r_cur_bx <= mem_dat_stream[HDR_BX_LSB +: BX_W];
            end
            if (w_write) begin
                wr_addr <= {r_cur_bx, w_cnt};
                wr_dat  <= mem_dat_stream;
            end
            if (w_close) begin
                number_out <= w_pub_cnt;
                number_BX  <= r_cur_bx;
            end
            if (w_lost) begin
                overflow <= 1'b1;
            end
            if (w_drop && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_page_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_page_writer
// Brief    : Vector table, corner sequences and random stream vs page model.
// Revision : 1.0
// ============================================================================
module tb_stream_page_writer;

    import stream_link_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DAT_W-1:0]  mem_dat_stream = '0;
    logic              valid = 1'b0;
    logic              send_BX = 1'b0;
    logic              flush = 1'b0;
    logic              wr_en;
    logic [BX_W+CNT_W-1:0] wr_addr;
    logic [DAT_W-1:0]  wr_dat;
    logic [CNT_W-1:0]  number_out;
    logic [BX_W-1:0]   number_BX;
    logic              number_valid;
    logic              overflow;
    logic [7:0]        dropped;

    always #5 clk = ~clk;

    stream_page_writer dut (
        .clk            (clk),
        .reset          (reset),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .send_BX        (send_BX),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_dat         (wr_dat),
        .number_out     (number_out),
        .number_BX      (number_BX),
        .number_valid   (number_valid),
        .overflow       (overflow),
        .dropped        (dropped)
    );

    int checks = 0;
    int errors = 0;

    // Page model: open flag, page BX, words stored, drop/overflow bookkeeping.
    bit          m_open;
    int          m_bx, m_cnt, m_drop;
    bit          m_ovf;
    bit          e_wr, e_nv;
    int          e_addr, e_nout, e_nbx;
    logic [DAT_W-1:0] e_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit v, input bit s, input bit f, input bit r,
                              input logic [DAT_W-1:0] d);
        e_wr = 0;
        e_nv = 0;
        if (r) begin
            m_open = 0; m_bx = 0; m_cnt = 0; m_drop = 0; m_ovf = 0;
        end else if (s) begin
            if (m_open) begin
                e_nv = 1; e_nout = m_cnt; e_nbx = m_bx;
            end
            m_open = 1;
            m_bx   = int'(d[BX_W-1:0]);
            m_cnt  = 0;
        end else begin
            if (v) begin
                if (m_open && m_cnt < MAX_ITEMS) begin
                    e_wr = 1; e_addr = m_bx * (MAX_ITEMS + 1) + m_cnt; e_dat = d;
                    m_cnt++;
                end else begin
                    if (m_drop < 255) m_drop++;
                    if (m_open) m_ovf = 1;
                end
            end
            if (f && m_open) begin
                e_nv = 1; e_nout = m_cnt; e_nbx = m_bx;
                m_open = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("wr_en", 64'(wr_en), 64'(e_wr));
        if (e_wr) begin
            chk("wr_addr", 64'(wr_addr), 64'(e_addr));
            chk("wr_dat", 64'(wr_dat), 64'(e_dat));
        end
        chk("number_valid", 64'(number_valid), 64'(e_nv));
        if (e_nv) begin
            chk("number_out", 64'(number_out), 64'(e_nout));
            chk("number_BX", 64'(number_BX), 64'(e_nbx));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("dropped", 64'(dropped), 64'(m_drop));
    endtask

    task automatic step(input bit v, input bit s, input bit f, input bit r,
                        input logic [DAT_W-1:0] d);
        valid = v; send_BX = s; flush = f; reset = r; mem_dat_stream = d;
        model_step(v, s, f, r, d);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_dat"}, 64'(wr_dat), 64'd0);
        chk({tag, "_number_out"}, 64'(number_out), 64'd0);
        chk({tag, "_number_BX"}, 64'(number_BX), 64'd0);
        chk({tag, "_number_valid"}, 64'(number_valid), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_dropped"}, 64'(dropped), 64'd0);
    endtask

    typedef struct {
        bit         v, s, f;
        logic [DAT_W-1:0] d;
        bit         ewr;
        int         eaddr;
        bit         env;
        int         enout, enbx;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DAT_W-1:0] wd(input int i);
        return {22'h2A5A5A, 32'(i * 32'h01010101 + 7)};
    endfunction

    initial begin
        // Header/data/flush sequences with hand-derived outputs (inputs -> outputs next cycle).
        tbl.push_back('{0,1,0, 54'd5,   0, 0,     0, 0, 0});
        tbl.push_back('{1,0,0, wd(0),   1, 'h140, 0, 0, 0});
        tbl.push_back('{1,0,0, wd(1),   1, 'h141, 0, 0, 0});
        tbl.push_back('{1,0,0, wd(2),   1, 'h142, 0, 0, 0});
        tbl.push_back('{0,0,1, 54'd0,   0, 0,     1, 3, 5});
        tbl.push_back('{0,0,0, 54'd0,   0, 0,     0, 0, 0});
        tbl.push_back('{0,1,0, 54'd2,   0, 0,     0, 0, 0});
        tbl.push_back('{1,0,0, wd(3),   1, 'h080, 0, 0, 0});
        tbl.push_back('{0,1,0, 54'd7,   0, 0,     1, 1, 2});
        tbl.push_back('{1,0,0, wd(4),   1, 'h1C0, 0, 0, 0});
        tbl.push_back('{1,0,0, wd(5),   1, 'h1C1, 0, 0, 0});
        tbl.push_back('{0,1,0, 54'd0,   0, 0,     1, 2, 7});
        tbl.push_back('{0,0,1, 54'd0,   0, 0,     1, 0, 0});
        tbl.push_back('{0,0,1, 54'd0,   0, 0,     0, 0, 0});
        tbl.push_back('{0,1,0, 54'd3,   0, 0,     0, 0, 0});
        tbl.push_back('{0,1,1, 54'd3,   0, 0,     1, 0, 3});
        tbl.push_back('{0,0,1, 54'd0,   0, 0,     1, 0, 3});

        step(0, 0, 0, 1, '0);
        step(0, 0, 0, 1, '0);
        chk_all_zero("reset");

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].f, 0, tbl[i].d);
            chk($sformatf("tbl%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].ewr));
            if (tbl[i].ewr) chk($sformatf("tbl%0d_wr_addr", i), 64'(wr_addr), 64'(tbl[i].eaddr));
            chk($sformatf("tbl%0d_nv", i), 64'(number_valid), 64'(tbl[i].env));
            if (tbl[i].env) begin
                chk($sformatf("tbl%0d_nout", i), 64'(number_out), 64'(tbl[i].enout));
                chk($sformatf("tbl%0d_nbx", i), 64'(number_BX), 64'(tbl[i].enbx));
            end
        end

        // Page overflow: 65 words into BX=1.
        step(0, 0, 0, 1, '0);
        step(0, 1, 0, 0, 54'd1);
        for (int i = 0; i < 65; i++) step(1, 0, 0, 0, wd(i));
        chk("ovf_overflow", 64'(overflow), 64'd1);
        chk("ovf_dropped", 64'(dropped), 64'd2);
        step(0, 0, 1, 0, '0);
        chk("ovf_number_out", 64'(number_out), 64'd63);

        // Data before any header, then header+valid together.
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, wd(i));
        step(1, 1, 0, 0, 54'd4);
        chk("prehdr_dropped", 64'(dropped), 64'd4);
        chk("prehdr_no_write", 64'(wr_en), 64'd0);
        step(1, 0, 0, 0, wd(9));
        chk("prehdr_bx4_addr", 64'(wr_addr), 64'h100);

        // Data and flush together after five words.
        step(0, 0, 0, 1, '0);
        step(0, 1, 0, 0, 54'd2);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, wd(i));
        step(1, 0, 1, 0, wd(5));
        chk("dflush_addr", 64'(wr_addr), 64'h085);
        chk("dflush_nout", 64'(number_out), 64'd6);

        // Reset mid-page with a concurrent word.
        step(0, 0, 0, 1, '0);
        step(0, 1, 0, 0, 54'd6);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, wd(i));
        step(1, 0, 0, 1, wd(10));
        chk_all_zero("midrst");
        step(1, 0, 0, 0, wd(11));
        chk("midrst_idle_drop", 64'(dropped), 64'd1);

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) step(1, 0, 0, 0, wd(i));
        chk("drop_sat", 64'(dropped), 64'd255);

        // Random stream against the page model.
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 4000; i++) begin
            bit v, s, f, r;
            int hp;
            hp = (i < 2000) ? 6 : 1;
            v  = ($urandom_range(99) < 70);
            s  = ($urandom_range(99) < hp);
            f  = ($urandom_range(99) < 3);
            r  = ($urandom_range(999) < 3);
            step(v, s, f, r, {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_page_writer.md
# stream_page_writer

Receive-side counterpart of the merged memory readout stream. Accepts the single merged data stream (data words qualified by `valid`, BX headers qualified by `send_BX`) and writes each data word into an external BX-paged memory. Each page holds one BX's words. Publishes the per-page item count in the same 6-bit form the readout side consumes as its starting item count. Sits at the far end of the inter-board link, feeding the downstream memories that the next readout stage drains.

## Interface
Parameters:
- `DAT_W`, 54: stream word width
- `BX_W`, 3: BX field width; number of pages = 2^BX_W
- `CNT_W`, 6: per-page address/count width
- `MAX_ITEMS`, 63: page capacity in words (2^CNT_W − 1)

Ports:
- `clk`  in  1  processing clock
- `reset`  in  1  synchronous, active-high; clears all state
- `mem_dat_stream`  in  DAT_W  merged stream word
- `valid`  in  1  stream word is a data word
- `send_BX`  in  1  stream word is a header; BX is `mem_dat_stream[BX_W-1:0]`
- `flush`  in  1  single-cycle pulse: close the open page with no new header (driven from upstream `none`, edge-detected externally)
- `wr_en`  out  1  memory write strobe
- `wr_addr`  out  BX_W+CNT_W  `{page BX, item index}`
- `wr_dat`  out  DAT_W  word to write
- `number_out`  out  CNT_W  item count of the page just closed
- `number_BX`  out  BX_W  BX of the page just closed
- `number_valid`  out  1  one-cycle pulse qualifying `number_out`/`number_BX`
- `overflow`  out  1  sticky: a word was lost to a full page
- `dropped`  out  8  saturating count of discarded data words

## Operation
- FSM states: IDLE (no open page), FILL (page open, BX held in `cur_bx`, item count in `cnt`).
- Header cycle (`send_BX`=1) has priority over `valid`. The word is never written.
  - In IDLE: load `cur_bx`, clear `cnt`, go to FILL.
  - In FILL: close the current page (publish `cnt`, `cur_bx`), load the new BX, clear `cnt`, stay in FILL. A header repeating the current BX closes and reopens that page.
- Data cycle (`valid`=1, `send_BX`=0):
  - In FILL with `cnt` < MAX_ITEMS: write at `{cur_bx, cnt}`, then `cnt`++.
  - In FILL with `cnt` = MAX_ITEMS: no write, set `overflow`, `dropped`++.
  - In IDLE: no write, `dropped`++. `overflow` is unaffected.
- `flush` in FILL: close the page, go to IDLE. `flush` in IDLE: no effect.
- `flush` coincident with a header: the header wins and `flush` is ignored.
- `flush` coincident with a data word: the word is written first. The published count includes it.
- Empty page (header followed by header or flush): publishes `number_out`=0 with `number_valid` pulsed.
- `dropped` saturates at 255. `overflow` is cleared only by `reset`.
- Reset values:
  - all outputs 0
  - FSM in IDLE, `cnt`=0, `cur_bx`=0
- `reset` mid-page discards the open page without a publish. A write already registered in the reset cycle is suppressed (`wr_en`=0 the next cycle).

## Timing
- All outputs registered.
- Accepted data word at cycle N: `wr_en`, `wr_addr`, `wr_dat` valid at N+1 for one cycle.
- Closing event (header or flush) at N: `number_valid` high at N+1 with the final count, including a data word written at N via the simultaneous-flush rule.
- Back-to-back data words: one write per cycle, no bubbles. Gaps in `valid` are tolerated.
- Header at N followed by data at N+1: the data writes to the new page at index 0.
- Throughput: 1 word/clk sustained.

## Structure
- Shared package `stream_link_pkg`:
  - `DAT_W`, `BX_W`, `CNT_W`, `MAX_ITEMS`
  - header BX field position
  - FSM state enum `{IDLE, FILL}`
- The header field definition must match the readout side's header generation.
- One sub-module: `page_item_counter`. It holds the `cnt` clear/increment/full logic and outputs `full` = (`cnt` == MAX_ITEMS). The top holds the FSM, `cur_bx`, the output registers and the `dropped`/`overflow` logic.

## Test plan
- Header BX=5, then 3 data words D0..D2, then `flush` → writes at 0x140, 0x141, 0x142. Then `number_valid` with `number_out`=3, `number_BX`=5.
- Header BX=2, 1 word, header BX=7, 2 words, header BX=0 → publishes (2,1), then (7,2), each one cycle after its closing header. Writes go to 0x080, 0x1C0, 0x1C1.
- Header BX=1, 65 data words → 63 writes (index 0..62), `overflow`=1, `dropped`=2. A subsequent `flush` publishes `number_out`=63.
- 4 data words before any header, then `send_BX` and `valid` together with BX=4 → no writes, `dropped`=4, FILL entered with BX=4.
- Data word and `flush` in the same cycle after 5 prior words → write at index 5, `number_out`=6.
- 10 words into BX=6, then `reset` concurrent with an 11th word → no write the next cycle, no `number_valid`, all outputs 0, FSM back in IDLE.
